// File: rtl/reg_scoreboard.sv
// Issue scoreboard for the 8x16b register file: stall/issue are combinational, busy is registered.
// Holds decode via stall; optional stall statistics under REG_SCOREBOARD_STATS_EN.
module reg_scoreboard #(
   parameter int DEPTH = 3,
   parameter int CW    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issueValid,
   input  logic [2:0]  src1Sel,
   input  logic        src1Used,
   input  logic [2:0]  src2Sel,
   input  logic        src2Used,
   input  logic [2:0]  dstSel,
   input  logic        dstWrite,
   input  logic        flush,
   output logic        stall,
   output logic        issue,
   output logic [7:0]  busy,
   output logic [15:0] stallCycles
);

   logic [7:0][CW-1:0] cnt;
   logic [7:0][CW-1:0] cnt_nxt;
   logic               hazard1;
   logic               hazard2;

   // A count of 1 means the write lands this cycle and is bypassed, so only >1 blocks.
   assign hazard1 = src1Used && (cnt[src1Sel] > CW'(1));
   assign hazard2 = src2Used && (cnt[src2Sel] > CW'(1));
   assign stall   = issueValid && !flush && (hazard1 || hazard2);
   assign issue   = issueValid && !flush && !stall;

   always_comb begin
      for (int r = 0; r < 8; r++) begin
         cnt_nxt[r] = cnt[r];
         if (flush)
            cnt_nxt[r] = '0;
         else if (issue && dstWrite && (dstSel == 3'(r)))
            cnt_nxt[r] = CW'(DEPTH);
         else if (cnt[r] != '0)
            cnt_nxt[r] = cnt[r] - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt  <= '0;
         busy <= '0;
      end else begin
         cnt <= cnt_nxt;
         for (int r = 0; r < 8; r++)
            busy[r] <= (cnt_nxt[r] != '0);
      end
   end

`ifdef REG_SCOREBOARD_STATS_EN
   // Saturating; survives flush, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst)
         stallCycles <= '0;
      else if (stall && (stallCycles != 16'hFFFF))
         stallCycles <= stallCycles + 16'd1;
   end
`else
   assign stallCycles = 16'h0000;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: DEPTH=3 and DEPTH=1 instances against a write-landing-time model.
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        issueValid = 1'b0;
   logic [2:0]  src1Sel = '0;
   logic        src1Used = 1'b0;
   logic [2:0]  src2Sel = '0;
   logic        src2Used = 1'b0;
   logic [2:0]  dstSel = '0;
   logic        dstWrite = 1'b0;
   logic        flush = 1'b0;

   logic        stall0, issue0, stall1, issue1;
   logic [7:0]  busy0, busy1;
   logic [15:0] sc0, sc1;

`ifdef REG_SCOREBOARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   reg_scoreboard #(.DEPTH(3), .CW(3)) dut (
      .clk(clk), .rst(rst), .issueValid(issueValid),
      .src1Sel(src1Sel), .src1Used(src1Used), .src2Sel(src2Sel), .src2Used(src2Used),
      .dstSel(dstSel), .dstWrite(dstWrite), .flush(flush),
      .stall(stall0), .issue(issue0), .busy(busy0), .stallCycles(sc0)
   );

   reg_scoreboard #(.DEPTH(1), .CW(3)) dut1 (
      .clk(clk), .rst(rst), .issueValid(issueValid),
      .src1Sel(src1Sel), .src1Used(src1Used), .src2Sel(src2Sel), .src2Used(src2Used),
      .dstSel(dstSel), .dstWrite(dstWrite), .flush(flush),
      .stall(stall1), .issue(issue1), .busy(busy1), .stallCycles(sc1)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model: land[k][r] is the cycle index in which the pending write to r reaches the register file.
   int cyc = 0;
   int land[2][8];
   int stats_m = 0;
   bit mvalid = 1'b0;

   function automatic int dep(int k);
      return (k == 0) ? 3 : 1;
   endfunction

   function automatic bit hz(int k, logic [2:0] sel, logic used);
      return used && (cyc < land[k][sel]);
   endfunction

   function automatic bit exp_stall(int k);
      return issueValid && !flush && (hz(k, src1Sel, src1Used) || hz(k, src2Sel, src2Used));
   endfunction

   function automatic bit exp_issue(int k);
      return issueValid && !flush && !exp_stall(k);
   endfunction

   function automatic logic [7:0] exp_busy(int k);
      logic [7:0] b;
      for (int r = 0; r < 8; r++) b[r] = (cyc <= land[k][r]);
      return b;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++)
            for (int r = 0; r < 8; r++) land[k][r] = -100;
         stats_m = 0;
         mvalid = 1'b1;
      end else if (mvalid) begin
         if (exp_stall(0) && stats_m != 65535) stats_m++;
         for (int k = 0; k < 2; k++) begin
            if (flush) begin
               for (int r = 0; r < 8; r++) land[k][r] = -100;
            end else if (exp_issue(k) && dstWrite) begin
               land[k][dstSel] = cyc + dep(k);
            end
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (mvalid) begin
         check("m_stall3", {31'd0, stall0}, {31'd0, exp_stall(0)});
         check("m_issue3", {31'd0, issue0}, {31'd0, exp_issue(0)});
         check("m_busy3", {24'd0, busy0}, {24'd0, exp_busy(0)});
         check("m_stats3", {16'd0, sc0}, STATS ? stats_m : 0);
         check("m_stall1", {31'd0, stall1}, 32'd0);
         check("m_issue1", {31'd0, issue1}, {31'd0, exp_issue(1)});
         check("m_busy1", {24'd0, busy1}, {24'd0, exp_busy(1)});
         check("m_stats1", {16'd0, sc1}, 32'd0);
      end
   end

   task automatic go(input bit r, input bit iv, input int s1, input bit u1,
                     input int s2, input bit u2, input int d, input bit dw, input bit fl);
      @(posedge clk);
      #1;
      rst = r; issueValid = iv;
      src1Sel = 3'(s1); src1Used = u1; src2Sel = 3'(s2); src2Used = u2;
      dstSel = 3'(d); dstWrite = dw; flush = fl;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) go(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset held two cycles with a valid instruction presented.
      go(0, 1, 0, 0, 0, 0, 0, 0, 0);
      go(0, 1, 0, 0, 0, 0, 0, 0, 0);
      check("rst_busy", {24'd0, busy0}, 32'h00);
      check("rst_stall", {31'd0, stall0}, 32'd0);
      check("rst_issue", {31'd0, issue0}, 32'd1);
      check("rst_stats", {16'd0, sc0}, 32'd0);

      // RAW on r5: busy for 3 cycles, reader blocked while count is 3 and 2.
      go(1, 1, 0, 0, 0, 0, 5, 1, 0);
      check("raw_prod_issue", {31'd0, issue0}, 32'd1);
      go(1, 1, 5, 1, 0, 0, 0, 0, 0);
      check("raw_stall_a", {31'd0, stall0}, 32'd1);
      check("raw_busy_a", {24'd0, busy0}, 32'h20);
      go(1, 1, 5, 1, 0, 0, 0, 0, 0);
      check("raw_stall_b", {31'd0, stall0}, 32'd1);
      go(1, 1, 5, 1, 0, 0, 0, 0, 0);
      check("raw_issue", {31'd0, issue0}, 32'd1);
      check("raw_busy_c", {24'd0, busy0}, 32'h20);
      go(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("raw_busy_done", {24'd0, busy0}, 32'h00);

      // Independent registers.
      go(1, 1, 0, 0, 0, 0, 2, 1, 0);
      check("ind_issue_a", {31'd0, issue0}, 32'd1);
      go(1, 1, 3, 1, 4, 1, 0, 0, 0);
      check("ind_stall", {31'd0, stall0}, 32'd0);
      check("ind_issue_b", {31'd0, issue0}, 32'd1);
      idle(3);

      // WAW reload on r1: reader still blocked two cycles after the second write.
      go(1, 1, 0, 0, 0, 0, 1, 1, 0);
      go(1, 1, 0, 0, 0, 0, 1, 1, 0);
      check("waw_issue2", {31'd0, issue0}, 32'd1);
      go(1, 1, 1, 1, 0, 0, 0, 0, 0);
      check("waw_stall_a", {31'd0, stall0}, 32'd1);
      go(1, 1, 1, 1, 0, 0, 0, 0, 0);
      check("waw_stall_b", {31'd0, stall0}, 32'd1);
      go(1, 1, 1, 1, 0, 0, 0, 0, 0);
      check("waw_issue", {31'd0, issue0}, 32'd1);
      idle(3);

      // Flush during a stall.
      go(1, 1, 0, 0, 0, 0, 6, 1, 0);
      go(1, 1, 6, 1, 0, 0, 0, 0, 0);
      check("fl_stall_pre", {31'd0, stall0}, 32'd1);
      go(1, 1, 6, 1, 0, 0, 0, 0, 1);
      check("fl_stall", {31'd0, stall0}, 32'd0);
      check("fl_issue", {31'd0, issue0}, 32'd0);
      go(1, 1, 6, 1, 0, 0, 0, 0, 0);
      check("fl_busy", {24'd0, busy0}, 32'h00);
      check("fl_reissue", {31'd0, issue0}, 32'd1);
      check("stats_acc", {16'd0, sc0}, STATS ? 32'd5 : 32'd0);
      idle(3);

      // Reset asserted mid-stall.
      go(1, 1, 0, 0, 0, 0, 7, 1, 0);
      go(0, 1, 7, 1, 0, 0, 0, 0, 0);
      check("mrst_stall_pre", {31'd0, stall0}, 32'd1);
      go(1, 1, 7, 1, 0, 0, 0, 0, 0);
      check("mrst_stall", {31'd0, stall0}, 32'd0);
      check("mrst_busy", {24'd0, busy0}, 32'h00);
      check("mrst_stats", {16'd0, sc0}, 32'd0);

      // Randomized traffic; the per-cycle compare process checks everything.
      for (int i = 0; i < 1500; i++) begin
         go(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
